// File: rtl/acos_pkg.sv
// Shared definitions for the acos request scheduler.
//   ACOS_DATA_W : operand/result width of the shared acos unit
//   state_t     : scheduler FSM state encoding (IDLE / RUN / DRAIN)
//   tag_w()     : width of a requester index for a given requester count
package acos_pkg;

  localparam int ACOS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acos_sched_if.sv
// Arbitration bundle between the scheduler and its arbiter.
//   req   : per-requester request vector (already qualified by pause/state)
//   ptr   : priority pointer, index that is checked first
//   grant : one-hot grant, all zero when nothing is requested
// Modports: master drives req/ptr and reads grant; slave is the arbiter.
interface acos_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int TW = acos_pkg::tag_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [TW-1:0]      ptr;
  logic [NUM_REQ-1:0] grant;

  modport master (output req, output ptr, input grant);
  modport slave  (input req, input ptr, output grant);

endinterface

// File: rtl/acos_rr_arb.sv
// Combinational arbiter: NUM_REQ-wide request vector to one-hot grant.
// The search starts at arb.ptr and wraps; with ptr tied to 0 this is
// plain fixed priority (lowest index wins).
// Ports: arb (acos_sched_if.slave) -- req/ptr in, grant out.
module acos_rr_arb
  import acos_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  acos_sched_if.slave arb
);

  localparam int TW = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [TW-1:0]      idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = TW'((int'(arb.ptr) + i) % NUM_REQ);
      if (!found && arb.req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign arb.grant = grant;

endmodule

// File: rtl/acos_sched.sv
// Scheduler sharing one fixed-latency acos unit between NUM_REQ requesters.
// Build option: define ACOS_SCHED_RR_EN for round-robin arbitration
// (pointer moves to granted index + 1); otherwise fixed priority.
// Ports:
//   clk_in, rst_n_in           : clock, async active-low reset
//   req_valid_in/req_data_in   : per-requester operand offer
//   req_ready_out              : one-hot grant (combinational)
//   pause_in                   : stop accepting new requests
//   acos_data_out/valid_out    : registered operand to the acos unit
//   acos_result_in             : result, LATENCY cycles after acos_valid_out
//   res_valid_out/data/id      : registered result strobe with owner index
//   busy_out                   : any pipeline stage holds a valid entry
//   dbg_state_out              : current FSM state
// Handshake: a requester transfers in the cycle where req_valid_in and
// req_ready_out are both high; the requester may withdraw req_valid_in at
// any time before that. The result side has no backpressure.
module acos_sched
  import acos_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  localparam int TW = tag_w(NUM_REQ)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic [NUM_REQ-1:0]                    req_valid_in,
  input  logic [NUM_REQ-1:0][ACOS_DATA_W-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]                    req_ready_out,
  input  logic                                  pause_in,
  output logic [ACOS_DATA_W-1:0]                acos_data_out,
  output logic                                  acos_valid_out,
  input  logic [ACOS_DATA_W-1:0]                acos_result_in,
  output logic                                  res_valid_out,
  output logic [ACOS_DATA_W-1:0]                res_data_out,
  output logic [TW-1:0]                         res_id_out,
  output logic                                  busy_out,
  output state_t                                dbg_state_out
);

  state_t             state, state_nxt;
  logic               accept;
  logic               hs;
  logic [TW-1:0]      hs_idx;
  logic [TW-1:0]      ptr;
  logic [TW-1:0]      iss_tag;
  logic [LATENCY-1:0] pv;
  logic [TW-1:0]      pt [LATENCY];
  logic               busy;

  acos_sched_if #(.NUM_REQ(NUM_REQ)) arb ();

  acos_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .arb (arb.slave)
  );

  // rst_n_in gates the grant so req_ready_out is 0 throughout reset.
  assign accept        = rst_n_in && !pause_in && (state != ST_DRAIN);
  assign arb.req       = req_valid_in & {NUM_REQ{accept}};
  assign arb.ptr       = ptr;
  assign req_ready_out = arb.grant;
  assign hs            = |arb.grant;

  always_comb begin
    hs_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb.grant[i]) hs_idx = TW'(i);
    end
  end

`ifdef ACOS_SCHED_RR_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (hs_idx == TW'(NUM_REQ - 1)) ? '0 : hs_idx + TW'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Issue register: operand reaches the acos unit one cycle after the
  // handshake; data holds its last value when nothing is issued.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acos_valid_out <= 1'b0;
      acos_data_out  <= '0;
      iss_tag        <= '0;
    end else begin
      acos_valid_out <= hs;
      if (hs) begin
        acos_data_out <= req_data_in[hs_idx];
        iss_tag       <= hs_idx;
      end
    end
  end

  // Tag/valid shadow of the acos unit: the last stage lines up with
  // acos_result_in for the operand issued LATENCY cycles earlier.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pv <= '0;
      for (int k = 0; k < LATENCY; k++) pt[k] <= '0;
    end else begin
      pv[0] <= acos_valid_out;
      pt[0] <= iss_tag;
      for (int k = 1; k < LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pt[k] <= pt[k-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_valid_out <= 1'b0;
      res_data_out  <= '0;
      res_id_out    <= '0;
    end else begin
      res_valid_out <= pv[LATENCY-1];
      if (pv[LATENCY-1]) begin
        res_data_out <= acos_result_in;
        res_id_out   <= pt[LATENCY-1];
      end
    end
  end

  assign busy     = acos_valid_out || (|pv) || res_valid_out;
  assign busy_out = busy;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hs) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (pause_in && busy)  state_nxt = ST_DRAIN;
        else if (!busy && !hs) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!busy)          state_nxt = ST_IDLE;
        else if (!pause_in) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state_out = state;

endmodule

// File: doc/acos_sched.md
ACOS_SCHED -- requirements
Module: acos_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 2, fixed cycles from acos_valid_out to the matching acos_result_in.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_in  input  NUM_REQ  per-requester operand valid.
REQ-006 SHALL have port req_data_in  input  NUM_REQ x 32  per-requester acos operand.
REQ-007 SHALL have port req_ready_out  output  NUM_REQ  per-requester grant; transfer when valid & ready.
REQ-008 SHALL have port pause_in  input  1  stop accepting new requests.
REQ-009 SHALL have port acos_data_out  output  32  operand to the shared acos unit.
REQ-010 SHALL have port acos_valid_out  output  1  operand strobe to the acos unit.
REQ-011 SHALL have port acos_result_in  input  32  result from the acos unit.
REQ-012 SHALL have port res_valid_out  output  1  one-cycle result strobe, no backpressure.
REQ-013 SHALL have port res_data_out  output  32  returned result.
REQ-014 SHALL have port res_id_out  output  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-015 SHALL have port busy_out  output  1  high while any operation is in flight.

Function
REQ-016 SHALL assert at most one req_ready_out bit per cycle, combinationally, only to a requester with req_valid_in high.
REQ-017 SHALL grant no requester while pause_in is high or the state is DRAIN.
REQ-018 SHALL register the granted operand so that acos_valid_out and acos_data_out appear exactly 1 cycle after the handshake; one issue per cycle maximum.
REQ-019 SHALL carry the granted index through a LATENCY-deep tag/valid shift register aligned with the acos unit.
REQ-020 SHALL register acos_result_in with its tag, producing res_valid_out, res_data_out and res_id_out at handshake cycle + 2 + LATENCY.
REQ-021 SHALL return results in issue order; back-to-back issues yield back-to-back results.
REQ-022 SHALL implement states IDLE (nothing in flight), RUN (issued work in flight, accepting), DRAIN (pause_in high with work in flight).
REQ-023 SHALL transition IDLE->RUN on a handshake, RUN->DRAIN on pause_in with work in flight, RUN->IDLE when the pipe is empty and no handshake occurs, DRAIN->IDLE when the pipe is empty, and DRAIN->RUN when pause_in falls with work still in flight.
REQ-024 SHALL drive busy_out high whenever any stage, including the output register, holds a valid entry.
REQ-025 SHALL hold acos_data_out and res_data_out at their last values when the respective valid is low.
REQ-026 SHALL drop a requester that deasserts req_valid_in without a handshake, with no side effect.

Reset
REQ-027 SHALL on rst_n_in low immediately clear all valid bits, tags, the state (to IDLE) and the priority pointer (to 0), and drive every output to 0.
REQ-028 SHALL discard in-flight operations on reset mid-operation, producing no res_valid_out for them after release.

Configuration
REQ-029 SHALL use macro ACOS_SCHED_RR_EN; when defined, arbitration is round-robin, with the pointer moving to granted index + 1 (mod NUM_REQ) after each handshake.
REQ-030 SHALL, when ACOS_SCHED_RR_EN is undefined, use fixed priority (lowest index wins) with no pointer register.

Structure
REQ-031 SHALL place ACOS_DATA_W = 32, the state enum type and the tag type width function in shared package acos_pkg.
REQ-032 SHALL contain one sub-module, acos_rr_arb (NUM_REQ-wide request -> one-hot grant, pointer input), instantiated in both configurations.

Verification
REQ-033 SHALL cover: single request, req 2 data 0x4000_0000 at cycle 10, LATENCY=2 -> acos_valid_out at 11; res_valid_out at 14 with res_id_out=2 and data equal to the model acos value.
REQ-034 SHALL cover: all 4 requesters valid continuously with RR -> grants 0,1,2,3,0 on consecutive cycles and results returned in the same order with no gaps.
REQ-035 SHALL cover: the same stimulus as REQ-034 without ACOS_SCHED_RR_EN -> requester 0 granted every cycle.
REQ-036 SHALL cover: pause_in raised with 2 ops in flight -> no grants; both results still delivered; busy_out falls the cycle after the last res_valid_out; state DRAIN->IDLE.
REQ-037 SHALL cover: rst_n_in pulsed low for 1 cycle with 2 ops in flight -> outputs 0 asynchronously and no res_valid_out for 5 cycles after release.
